// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM: sequences R-type, LW, SW, BEQ, ADDI and J
// over 3-5 cycles, stalls on mem_ready, pulses illegalOp on unknown opcodes.
// Ports: clk, reset (sync, active-high), op, zero, mem_ready in;
//   mem_req, iorD, memWrite, irWrite, regDst, memToReg, regWrite,
//   aluSrcA, aluSrcB, aluOp, pcSrc, branch, pcWrite, pcEn,
//   instrDone, illegalOp out (all forced 0 while reset is high).
`timescale 1ns/1ps
module multicycle_controller #(
  parameter int OP_W = 6,
  parameter int ALUOP_W = 2,
  parameter int MEM_WAIT = 1,
  parameter logic [OP_W-1:0] OP_RTYPE = 6'h00,
  parameter logic [OP_W-1:0] OP_J = 6'h02,
  parameter logic [OP_W-1:0] OP_BEQ = 6'h04,
  parameter logic [OP_W-1:0] OP_ADDI = 6'h08,
  parameter logic [OP_W-1:0] OP_LW = 6'h23,
  parameter logic [OP_W-1:0] OP_SW = 6'h2B
) (
  input  logic clk,
  input  logic reset,
  input  logic [OP_W-1:0] op,
  input  logic zero,
  input  logic mem_ready,
  output logic mem_req,
  output logic iorD,
  output logic memWrite,
  output logic irWrite,
  output logic regDst,
  output logic memToReg,
  output logic regWrite,
  output logic aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [ALUOP_W-1:0] aluOp,
  output logic [1:0] pcSrc,
  output logic branch,
  output logic pcWrite,
  output logic pcEn,
  output logic instrDone,
  output logic illegalOp
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BEQ    = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11
  } state_t;

  state_t state, next;
  logic ready;

  assign ready = (MEM_WAIT == 0) ? 1'b1 : mem_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= next;
  end

  always_comb begin
    next      = FETCH;
    mem_req   = 1'b0;
    iorD      = 1'b0;
    memWrite  = 1'b0;
    irWrite   = 1'b0;
    regDst    = 1'b0;
    memToReg  = 1'b0;
    regWrite  = 1'b0;
    aluSrcA   = 1'b0;
    aluSrcB   = 2'b00;
    aluOp     = '0;
    pcSrc     = 2'b00;
    branch    = 1'b0;
    pcWrite   = 1'b0;
    instrDone = 1'b0;
    illegalOp = 1'b0;
    case (state)
      FETCH: begin
        mem_req = 1'b1;
        aluSrcB = 2'b01;
        irWrite = ready;
        pcWrite = ready;
        next    = ready ? DECODE : FETCH;
      end
      DECODE: begin
        aluSrcB = 2'b11;
        case (op)
          OP_LW, OP_SW: next = MEMADR;
          OP_RTYPE:     next = EXEC;
          OP_BEQ:       next = BEQ;
          OP_ADDI:      next = ADDIEX;
          OP_J:         next = JUMP;
          default: begin
            illegalOp = 1'b1;
            instrDone = 1'b1;
            next      = FETCH;
          end
        endcase
      end
      MEMADR: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
        next    = (op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        mem_req = 1'b1;
        iorD    = 1'b1;
        next    = ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        memToReg  = 1'b1;
        regWrite  = 1'b1;
        instrDone = 1'b1;
      end
      MEMWR: begin
        mem_req   = 1'b1;
        iorD      = 1'b1;
        memWrite  = ready;
        instrDone = ready;
        next      = ready ? FETCH : MEMWR;
      end
      EXEC: begin
        aluSrcA = 1'b1;
        aluOp   = ALUOP_W'(2);
        next    = ALUWB;
      end
      ALUWB: begin
        regDst    = 1'b1;
        regWrite  = 1'b1;
        instrDone = 1'b1;
      end
      BEQ: begin
        aluSrcA   = 1'b1;
        aluOp     = ALUOP_W'(1);
        pcSrc     = 2'b01;
        branch    = 1'b1;
        instrDone = 1'b1;
      end
      ADDIEX: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
        next    = ADDIWB;
      end
      ADDIWB: begin
        regWrite  = 1'b1;
        instrDone = 1'b1;
      end
      JUMP: begin
        pcSrc     = 2'b10;
        pcWrite   = 1'b1;
        instrDone = 1'b1;
      end
      default: next = FETCH;
    endcase
    // Reset quiesces the datapath so an abandoned instruction commits nothing.
    if (reset) begin
      mem_req   = 1'b0;
      iorD      = 1'b0;
      memWrite  = 1'b0;
      irWrite   = 1'b0;
      regDst    = 1'b0;
      memToReg  = 1'b0;
      regWrite  = 1'b0;
      aluSrcA   = 1'b0;
      aluSrcB   = 2'b00;
      aluOp     = '0;
      pcSrc     = 2'b00;
      branch    = 1'b0;
      pcWrite   = 1'b0;
      instrDone = 1'b0;
      illegalOp = 1'b0;
    end
  end

  assign pcEn = pcWrite | (branch & zero);

endmodule
